// File: rtl/vga_controller.sv
// vga_controller: 640x480 @ 60 Hz VGA timing generator.
// A divide-by-CLK_DIV strobe (p_tick) paces the horizontal and vertical
// pixel counters; hsync/vsync are registered from the next counter values,
// so they stay cycle-aligned with x/y.
// Optional feature macro: VGA_FRAME_TICK_EN adds a registered one-cycle
// frame_tick pulse after each wrap from the last pixel back to (0,0).
module vga_controller #(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned H_DISPLAY = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_DISPLAY = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       p_tick,
  output logic [9:0] x,
`ifdef VGA_FRAME_TICK_EN
  output logic [9:0] y,
  output logic       frame_tick
`else
  output logic [9:0] y
`endif
);

  localparam int unsigned CNT_W        = 10;
  localparam int unsigned DIV_W        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL      = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int unsigned V_SYNC_START = V_DISPLAY + V_FRONT;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  logic [DIV_W-1:0] r_div;
  logic [CNT_W-1:0] r_h_count;
  logic [CNT_W-1:0] r_v_count;
  logic             r_hsync;
  logic             r_vsync;

  logic             w_p_tick;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_hsync_next;
  logic             w_vsync_next;

  assign w_p_tick = (r_div == DIV_W'(CLK_DIV - 1));

  // Next counter values and the sync levels they imply
  always_comb begin
    w_h_wrap     = (r_h_count == CNT_W'(H_TOTAL - 1));
    w_v_wrap     = (r_v_count == CNT_W'(V_TOTAL - 1));
    w_h_next     = w_h_wrap ? '0 : r_h_count + CNT_W'(1);
    w_v_next     = r_v_count;
    if (w_h_wrap) begin
      w_v_next = w_v_wrap ? '0 : r_v_count + CNT_W'(1);
    end
    w_hsync_next = !((w_h_next >= CNT_W'(H_SYNC_START)) &&
                     (w_h_next <= CNT_W'(H_SYNC_END)));
    w_vsync_next = !((w_v_next >= CNT_W'(V_SYNC_START)) &&
                     (w_v_next <= CNT_W'(V_SYNC_END)));
  end

  // Free-running pixel clock divider
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_div <= '0;
    end else if (w_p_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Pixel/line counters and syncs advance together on p_tick
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
    end else if (w_p_tick) begin
      r_h_count <= w_h_next;
      r_v_count <= w_v_next;
      r_hsync   <= w_hsync_next;
      r_vsync   <= w_vsync_next;
    end
  end

`ifdef VGA_FRAME_TICK_EN
  logic r_frame_tick;

  // One-cycle pulse following the edge that wraps the frame to (0,0)
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_p_tick && w_h_wrap && w_v_wrap;
    end
  end

  assign frame_tick = r_frame_tick;
`endif

  assign p_tick   = w_p_tick;
  assign hsync    = r_hsync;
  assign vsync    = r_vsync;
  assign x        = r_h_count;
  assign y        = r_v_count;
  assign video_on = (r_h_count < CNT_W'(H_DISPLAY)) && (r_v_count < CNT_W'(V_DISPLAY));

endmodule

// File: tb/tb_vga_controller.sv
// Testbench for vga_controller: a default-timing instance for reset, divider
// and line timing, and a scaled-down instance (24x19 positions) so vertical
// timing, frame wrap and frame_tick fit in a short run.
module tb_vga_controller;

  localparam int SH_TOT = 24;          // 16 + 2 + 4 + 2
  localparam int SV_TOT = 19;          // 12 + 2 + 2 + 3
  localparam int SFRAME = SH_TOT * SV_TOT * 4;   // 1824 clk

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_big_n;
  logic       rst_small_n;
  logic       b_hs, b_vs, b_von, b_pt;
  logic [9:0] b_x, b_y;
  logic       s_hs, s_vs, s_von, s_pt;
  logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_TICK_EN
  logic       b_ft, s_ft;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_big;
  int n_small;

  vga_controller dut_big (
    .clk_100MHz (clk),
    .reset      (rst_big_n),
    .hsync      (b_hs),
    .vsync      (b_vs),
    .video_on   (b_von),
    .p_tick     (b_pt),
    .x          (b_x),
`ifdef VGA_FRAME_TICK_EN
    .y          (b_y),
    .frame_tick (b_ft)
`else
    .y          (b_y)
`endif
  );

  vga_controller #(
    .CLK_DIV(4), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
    .V_DISPLAY(12), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut_small (
    .clk_100MHz (clk),
    .reset      (rst_small_n),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .video_on   (s_von),
    .p_tick     (s_pt),
    .x          (s_x),
`ifdef VGA_FRAME_TICK_EN
    .y          (s_y),
    .frame_tick (s_ft)
`else
    .y          (s_y)
`endif
  );

  // Rising edges since each reset release
  always @(posedge clk or negedge rst_big_n)
    if (!rst_big_n) n_big <= 0; else n_big <= n_big + 1;
  always @(posedge clk or negedge rst_small_n)
    if (!rst_small_n) n_small <= 0; else n_small <= n_small + 1;

  // Position after n rising edges since release (pixel k reached on edge 4k)
  function automatic int exp_h(input int n, input int ht);
    return (n / 4) % ht;
  endfunction
  function automatic int exp_v(input int n, input int ht, input int vt);
    return ((n / 4) / ht) % vt;
  endfunction

  task automatic test_reset();
    rst_big_n = 1'b0; rst_small_n = 1'b0;
    #100;
    @(negedge clk);
    n_cmp++; if (b_hs !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b want 1", b_hs); end
    n_cmp++; if (b_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b want 1", b_vs); end
    n_cmp++; if (b_x !== 10'd0) begin n_bad++; $display("FAIL reset_x: got %0d want 0", b_x); end
    n_cmp++; if (b_y !== 10'd0) begin n_bad++; $display("FAIL reset_y: got %0d want 0", b_y); end
    n_cmp++; if (b_von !== 1'b1) begin n_bad++; $display("FAIL reset_video_on: got %b want 1", b_von); end
    n_cmp++; if (b_pt !== 1'b0) begin n_bad++; $display("FAIL reset_p_tick: got %b want 0", b_pt); end
    n_cmp++; if (s_x !== 10'd0 || s_y !== 10'd0) begin n_bad++; $display("FAIL reset_small_xy: got %0d,%0d want 0,0", s_x, s_y); end
`ifdef VGA_FRAME_TICK_EN
    n_cmp++; if (b_ft !== 1'b0) begin n_bad++; $display("FAIL reset_frame_tick: got %b want 0", b_ft); end
`endif
  endtask

  task automatic test_divider();
    @(negedge clk);
    rst_big_n = 1'b1; rst_small_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (b_pt !== ((i % 4) == 3)) begin
        n_bad++; $display("FAIL div_p_tick edge %0d: got %b want %b", i, b_pt, (i % 4) == 3);
      end
      n_cmp++;
      if (b_x !== 10'(i / 4)) begin
        n_bad++; $display("FAIL div_x edge %0d: got %0d want %0d", i, b_x, i / 4);
      end
      n_cmp++;
      if (s_pt !== ((i % 4) == 3)) begin
        n_bad++; $display("FAIL div_small_p_tick edge %0d: got %b want %b", i, s_pt, (i % 4) == 3);
      end
    end
  endtask

  task automatic test_horizontal();
    int h, v;
    int fall0 = -1, fall1 = -1, rise0 = -1;
    logic prev_hs, prev_von;
    logic [9:0] prev_x, prev_y;
    prev_hs = b_hs; prev_von = b_von; prev_x = b_x; prev_y = b_y;
    while (n_big < 6100) begin
      @(negedge clk);
      h = exp_h(n_big, 800);
      v = exp_v(n_big, 800, 525);
      n_cmp++; if (b_x !== 10'(h)) begin n_bad++; $display("FAIL h_x n=%0d: got %0d want %0d", n_big, b_x, h); end
      n_cmp++; if (b_y !== 10'(v)) begin n_bad++; $display("FAIL h_y n=%0d: got %0d want %0d", n_big, b_y, v); end
      n_cmp++; if (b_hs !== !(h >= 656 && h <= 751)) begin n_bad++; $display("FAIL h_hsync n=%0d x=%0d: got %b", n_big, h, b_hs); end
      n_cmp++; if (b_vs !== 1'b1) begin n_bad++; $display("FAIL h_vsync n=%0d: got %b want 1", n_big, b_vs); end
      n_cmp++; if (b_von !== (h < 640)) begin n_bad++; $display("FAIL h_video_on n=%0d x=%0d: got %b", n_big, h, b_von); end
      if (prev_hs && !b_hs) begin
        if (fall0 < 0) fall0 = n_big; else if (fall1 < 0) fall1 = n_big;
        n_cmp++; if (b_x !== 10'd656) begin n_bad++; $display("FAIL hsync_fall_x: got %0d want 656", b_x); end
      end
      if (!prev_hs && b_hs) begin
        if (rise0 < 0) rise0 = n_big;
        n_cmp++; if (b_x !== 10'd752) begin n_bad++; $display("FAIL hsync_rise_x: got %0d want 752", b_x); end
      end
      if (prev_von && !b_von) begin
        n_cmp++; if (b_x !== 10'd640) begin n_bad++; $display("FAIL video_off_x: got %0d want 640", b_x); end
      end
      if (prev_x == 10'd799 && b_x == 10'd0) begin
        n_cmp++; if (b_y !== prev_y + 10'd1) begin n_bad++; $display("FAIL h_wrap_y: got %0d want %0d", b_y, prev_y + 10'd1); end
      end
      prev_hs = b_hs; prev_von = b_von; prev_x = b_x; prev_y = b_y;
    end
    n_cmp++; if (fall1 - fall0 != 3200 || fall0 < 0 || fall1 < 0) begin n_bad++; $display("FAIL line_period: got %0d want 3200", fall1 - fall0); end
    n_cmp++; if (rise0 - fall0 != 384 || fall0 < 0 || rise0 < 0) begin n_bad++; $display("FAIL hsync_width: got %0d want 384", rise0 - fall0); end
  endtask

  task automatic test_vertical();
    int h, v, n_end;
    int fall0 = -1, fall1 = -1, rise0 = -1;
    logic prev_vs;
    logic [9:0] prev_x, prev_y;
    prev_vs = s_vs; prev_x = s_x; prev_y = s_y;
    n_end = n_small + 2 * SFRAME + 10;
    while (n_small < n_end) begin
      @(negedge clk);
      h = exp_h(n_small, SH_TOT);
      v = exp_v(n_small, SH_TOT, SV_TOT);
      n_cmp++; if (s_x !== 10'(h) || s_y !== 10'(v)) begin n_bad++; $display("FAIL v_xy n=%0d: got %0d,%0d want %0d,%0d", n_small, s_x, s_y, h, v); end
      n_cmp++; if (s_hs !== !(h >= 18 && h <= 21)) begin n_bad++; $display("FAIL v_hsync x=%0d: got %b", h, s_hs); end
      n_cmp++; if (s_vs !== !(v >= 14 && v <= 15)) begin n_bad++; $display("FAIL v_vsync y=%0d: got %b", v, s_vs); end
      n_cmp++; if (s_von !== (h < 16 && v < 12)) begin n_bad++; $display("FAIL v_video_on %0d,%0d: got %b", h, v, s_von); end
      if (prev_vs && !s_vs) begin
        if (fall0 < 0) fall0 = n_small; else if (fall1 < 0) fall1 = n_small;
      end
      if (!prev_vs && s_vs && fall0 >= 0 && rise0 < 0) rise0 = n_small;
      if (prev_x == 10'd23 && s_x == 10'd0) begin
        n_cmp++;
        if (s_y !== ((prev_y == 10'd18) ? 10'd0 : prev_y + 10'd1)) begin
          n_bad++; $display("FAIL v_step: got y=%0d after y=%0d", s_y, prev_y);
        end
      end
      prev_vs = s_vs; prev_x = s_x; prev_y = s_y;
    end
    n_cmp++; if (fall1 - fall0 != SFRAME || fall0 < 0 || fall1 < 0) begin n_bad++; $display("FAIL frame_period: got %0d want %0d", fall1 - fall0, SFRAME); end
    n_cmp++; if (rise0 - fall0 != 192 || fall0 < 0 || rise0 < 0) begin n_bad++; $display("FAIL vsync_width: got %0d want 192", rise0 - fall0); end
  endtask

  task automatic test_frame_wrap();
    bit found = 0;
    for (int i = 0; i < SFRAME + 8 && !found; i++) begin
      @(negedge clk);
      if (s_x == 10'd23 && s_y == 10'd18 && s_pt) found = 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL wrap_timeout: got no (23,18) tick want one"); end
    @(negedge clk);
    n_cmp++; if (s_x !== 10'd0 || s_y !== 10'd0) begin n_bad++; $display("FAIL wrap_xy: got %0d,%0d want 0,0", s_x, s_y); end
    n_cmp++; if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_von !== 1'b1) begin n_bad++; $display("FAIL wrap_flags: got hs=%b vs=%b von=%b want 1,1,1", s_hs, s_vs, s_von); end
`ifdef VGA_FRAME_TICK_EN
    n_cmp++; if (s_ft !== 1'b1) begin n_bad++; $display("FAIL wrap_frame_tick: got %b want 1", s_ft); end
`endif
    @(negedge clk);
    n_cmp++; if (s_x !== 10'd0 || s_pt !== 1'b0) begin n_bad++; $display("FAIL wrap_hold: got x=%0d pt=%b want 0,0", s_x, s_pt); end
`ifdef VGA_FRAME_TICK_EN
    n_cmp++; if (s_ft !== 1'b0) begin n_bad++; $display("FAIL wrap_frame_tick_end: got %b want 0", s_ft); end
`endif
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    // default instance, mid-line at x=300 on a nonzero line
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      if (b_x == 10'd300 && b_y != 10'd0) found = 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_big_timeout: got no x=300 want one"); end
    #2 rst_big_n = 1'b0;
    #1;
    n_cmp++; if (b_x !== 10'd0 || b_y !== 10'd0) begin n_bad++; $display("FAIL mid_big_xy: got %0d,%0d want 0,0", b_x, b_y); end
    n_cmp++; if (b_hs !== 1'b1 || b_vs !== 1'b1 || b_von !== 1'b1 || b_pt !== 1'b0) begin n_bad++; $display("FAIL mid_big_flags: got hs=%b vs=%b von=%b pt=%b want 1,1,1,0", b_hs, b_vs, b_von, b_pt); end
    // scaled instance, inside both sync pulses at (19,14)
    found = 0;
    for (int i = 0; i < SFRAME + 8 && !found; i++) begin
      @(negedge clk);
      if (s_x == 10'd19 && s_y == 10'd14) found = 1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL mid_small_timeout: got no (19,14) want one"); end
    n_cmp++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin n_bad++; $display("FAIL mid_small_pre: got hs=%b vs=%b want 0,0", s_hs, s_vs); end
    #2 rst_small_n = 1'b0;
    #1;
    n_cmp++; if (s_x !== 10'd0 || s_y !== 10'd0) begin n_bad++; $display("FAIL mid_small_xy: got %0d,%0d want 0,0", s_x, s_y); end
    n_cmp++; if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_von !== 1'b1) begin n_bad++; $display("FAIL mid_small_flags: got hs=%b vs=%b von=%b want 1,1,1", s_hs, s_vs, s_von); end
    @(negedge clk);
    @(negedge clk);
    rst_big_n = 1'b1; rst_small_n = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        n_cmp++; if (b_pt !== 1'b1 || b_x !== 10'd0) begin n_bad++; $display("FAIL restart_tick: got pt=%b x=%0d want 1,0", b_pt, b_x); end
      end
    end
    n_cmp++; if (b_x !== 10'd1 || b_y !== 10'd0) begin n_bad++; $display("FAIL restart_big_xy: got %0d,%0d want 1,0", b_x, b_y); end
    n_cmp++; if (s_x !== 10'd1 || s_y !== 10'd0) begin n_bad++; $display("FAIL restart_small_xy: got %0d,%0d want 1,0", s_x, s_y); end
  endtask

`ifdef VGA_FRAME_TICK_EN
  task automatic test_frame_tick();
    int pulses = 0, p0 = -1, p1 = -1;
    bit want;
    while (n_small < 2 * SFRAME + 8) begin
      @(negedge clk);
      want = (n_small > 0) && ((n_small % SFRAME) == 0);
      n_cmp++; if (s_ft !== want) begin n_bad++; $display("FAIL frame_tick n=%0d: got %b want %b", n_small, s_ft, want); end
      n_cmp++; if (b_ft !== 1'b0) begin n_bad++; $display("FAIL big_frame_tick n=%0d: got %b want 0", n_big, b_ft); end
      if (s_ft === 1'b1) begin
        pulses++;
        if (p0 < 0) p0 = n_small; else if (p1 < 0) p1 = n_small;
      end
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL frame_tick_count: got %0d want 2", pulses); end
    n_cmp++; if (p1 - p0 != SFRAME || p0 < 0 || p1 < 0) begin n_bad++; $display("FAIL frame_tick_spacing: got %0d want %0d", p1 - p0, SFRAME); end
  endtask
`endif

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_divider();
    test_horizontal();
    test_vertical();
    test_frame_wrap();
    test_mid_reset();
`ifdef VGA_FRAME_TICK_EN
    test_frame_tick();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
